// File: rtl/alu_param_pkg.sv
// Shared definitions for the parameterised ALU: op encoding, flag bit positions
// and the flag packing helper.
package alu_param_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic {
    MUL_IDLE,
    MUL_RUN
  } mul_state_e;

  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: consumes one multiplier bit per cycle,
// busy for exactly WIDTH cycles after a start.
module alu_mul_seq
  import alu_param_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_last,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mul_state_e         r_state;
  mul_state_e         w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_done;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last     = (r_state == MUL_RUN) && (r_cnt == LAST_CNT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MUL_IDLE: if (i_start) w_state_next = MUL_RUN;
      MUL_RUN:  if (w_last)  w_state_next = MUL_IDLE;
      default:  w_state_next = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= MUL_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_last;
      if (r_state == MUL_IDLE && i_start) begin
        r_mcand  <= {{WIDTH{1'b0}}, i_a};
        r_mplier <= i_b;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == MUL_RUN) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
      end
    end
  end

  // Product is exposed combinationally so the caller can latch it on the final step edge.
  assign o_busy    = (r_state == MUL_RUN);
  assign o_done    = r_done;
  assign o_last    = w_last;
  assign o_product = w_acc_next;

endmodule

// File: rtl/alu_param.sv
// Parameterised ALU: A and G registers, single-cycle datapath with {V,C,N,Z}
// flags, and a sequential multiplier for MUL.
module alu_param
  import alu_param_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] buswires,
  input  logic             ain,
  input  logic             gin,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] aluout,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_g;
  logic [3:0]         r_flags;

  op_e                w_op;
  logic               w_is_sub;
  logic [WIDTH-1:0]   w_b_eff;
  logic [WIDTH:0]     w_sum;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic [3:0]         w_fl;
  logic               w_busy;
  logic               w_done;
  logic               w_last;
  logic               w_start;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_mul_lo;
  logic [3:0]         w_mul_fl;

  assign w_op     = op_e'(op);
  assign w_is_sub = (w_op == OP_SUB);
  assign w_b_eff  = w_is_sub ? ~buswires : buswires;
  assign w_sum    = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_shamt  = buswires[SHW-1:0];
  // One guard bit on each shift catches the last bit shifted out (0 for amount 0).
  assign w_shl    = {1'b0, r_a} << w_shamt;
  assign w_shr    = {r_a, 1'b0} >> w_shamt;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND:  w_res = r_a & buswires;
      OP_OR:   w_res = r_a | buswires;
      OP_XOR:  w_res = r_a ^ buswires;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      default: w_res = '0;
    endcase
    w_fl = pack_flags(w_v, w_c, w_res[WIDTH-1], (w_res == '0));
  end

  assign w_start  = gin && (w_op == OP_MUL) && !w_busy;
  assign w_mul_lo = w_product[WIDTH-1:0];
  assign w_mul_fl = pack_flags(|w_product[2*WIDTH-1:WIDTH], |w_product[2*WIDTH-1:WIDTH],
                               w_mul_lo[WIDTH-1], (w_mul_lo == '0));

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_a      (r_a),
    .i_b      (buswires),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_last   (w_last),
    .o_product(w_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_g     <= '0;
      r_flags <= '0;
    end else begin
      if (ain && !w_busy) r_a <= buswires;
      if (w_last) begin
        r_g     <= w_mul_lo;
        r_flags <= w_mul_fl;
      end else if (gin && !w_busy && (w_op != OP_MUL)) begin
        r_g     <= w_res;
        r_flags <= w_fl;
      end
    end
  end

  assign aluout = r_g;
  assign flags  = r_flags;
  assign busy   = w_busy;
  assign done   = w_done;

endmodule

// File: tb/tb_alu_param.sv
// Scoreboard bench for alu_param (WIDTH=16): directed vectors push expected
// results, a negedge monitor pops and compares them as the DUT presents them.
module tb_alu_param;
  import alu_param_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] buswires;
  logic        ain;
  logic        gin;
  logic [2:0]  op;
  logic [15:0] aluout;
  logic [3:0]  flags;
  logic        busy;
  logic        done;

  alu_param #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .buswires(buswires), .ain(ain), .gin(gin), .op(op),
    .aluout(aluout), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    logic [3:0]  fl;
    bit          is_mul;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: single-cycle results are popped in their cycle, multiply results on done.
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    if (!rst) begin
      exp_busy = 1'b0;
      if (q.size() > 0 && q[0].is_mul)
        exp_busy = (cyc >= q[0].cyc - 16) && (cyc < q[0].cyc);
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      if (q.size() > 0 && q[0].is_mul) begin
        if (done) begin
          e = q.pop_front();
          chk({e.name, " done cycle"}, cyc, e.cyc);
          chk({e.name, " aluout"}, {16'b0, aluout}, {16'b0, e.val});
          chk({e.name, " flags"}, {28'b0, flags}, {28'b0, e.fl});
        end else if (cyc > q[0].cyc) begin
          e = q.pop_front();
          chk({e.name, " done timeout"}, 32'd0, 32'd1);
        end
      end else begin
        chk("stray done", {31'b0, done}, 32'd0);
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          chk({e.name, " cycle"}, cyc, e.cyc);
          chk({e.name, " aluout"}, {16'b0, aluout}, {16'b0, e.val});
          chk({e.name, " flags"}, {28'b0, flags}, {28'b0, e.fl});
        end
      end
    end
  end

  task automatic drive(input logic a, input logic g, input op_e o, input logic [15:0] b);
    ain = a; gin = g; op = o; buswires = b;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, OP_ADD, 16'h0000);
  endtask

  task automatic load(input logic [15:0] b);
    drive(1'b1, 1'b0, OP_ADD, b);
  endtask

  task automatic alu(input string n, input op_e o, input logic [15:0] b,
                     input logic [15:0] val, input logic [3:0] fl);
    q.push_back('{cyc + 1, val, fl, 1'b0, n});
    drive(1'b0, 1'b1, o, b);
  endtask

  task automatic mul(input string n, input logic [15:0] b,
                     input logic [15:0] val, input logic [3:0] fl);
    q.push_back('{cyc + 17, val, fl, 1'b1, n});
    drive(1'b0, 1'b1, OP_MUL, b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ain = 1'b0; gin = 1'b0; op = OP_ADD; buswires = '0;
    #1;
    chk("reset aluout", {16'b0, aluout}, 32'd0);
    chk("reset flags",  {28'b0, flags},  32'd0);
    chk("reset busy",   {31'b0, busy},   32'd0);
    chk("reset done",   {31'b0, done},   32'd0);
    @(negedge clk); #1;
    rst = 1'b0;

    alu("add A=0",   OP_ADD, 16'h0007, 16'h0007, 4'b0000);
    load(16'h0005);
    alu("add 5+3",   OP_ADD, 16'h0003, 16'h0008, 4'b0000);
    load(16'h0003);
    alu("sub 3-5",   OP_SUB, 16'h0005, 16'hFFFE, 4'b0010);
    load(16'h7FFF);
    alu("add ovf",   OP_ADD, 16'h0001, 16'h8000, 4'b1010);
    load(16'hFFFF);
    alu("add wrap",  OP_ADD, 16'h0001, 16'h0000, 4'b0101);
    load(16'h0005);
    alu("sub 5-3",   OP_SUB, 16'h0003, 16'h0002, 4'b0100);
    alu("sub 5-5",   OP_SUB, 16'h0005, 16'h0000, 4'b0101);
    load(16'h8000);
    alu("sub ovf",   OP_SUB, 16'h0001, 16'h7FFF, 4'b1100);
    load(16'hF0F0);
    alu("and",       OP_AND, 16'hFF00, 16'hF000, 4'b0010);
    alu("or",        OP_OR,  16'hFF00, 16'hFFF0, 4'b0010);
    alu("xor",       OP_XOR, 16'hFF00, 16'h0FF0, 4'b0000);
    load(16'h8001);
    alu("shl 1",     OP_SHL, 16'h0001, 16'h0002, 4'b0100);
    alu("shl 0x11",  OP_SHL, 16'h0011, 16'h0002, 4'b0100);
    alu("shr 15",    OP_SHR, 16'h000F, 16'h0001, 4'b0000);
    alu("shr 1",     OP_SHR, 16'h0001, 16'h4000, 4'b0100);
    alu("shl 0",     OP_SHL, 16'h0000, 16'h8001, 4'b0010);
    q.push_back('{cyc + 1, 16'h8011, 4'b0010, 1'b0, "ain+gin old A"});
    drive(1'b1, 1'b1, OP_ADD, 16'h0010);
    alu("new A",     OP_ADD, 16'h0001, 16'h0011, 4'b0000);

    load(16'h0012);
    mul("mul 12x34", 16'h0034, 16'h03A8, 4'b0000);
    idle(); idle();
    drive(1'b1, 1'b1, OP_ADD, 16'hAAAA);
    drive(1'b0, 1'b1, OP_MUL, 16'h5555);
    chk("G hold aluout", {16'b0, aluout}, 32'h0000_0011);
    chk("G hold flags",  {28'b0, flags},  32'd0);
    repeat (12) idle();
    alu("b2b A held", OP_ADD, 16'h0000, 16'h0012, 4'b0000);

    load(16'h0100);
    mul("mul 100x100", 16'h0100, 16'h0000, 4'b1101);
    repeat (16) idle();
    alu("b2b after mul", OP_ADD, 16'h0000, 16'h0100, 4'b0000);

    load(16'h0012);
    mul("mul aborted", 16'h0034, 16'h03A8, 4'b0000);
    repeat (4) idle();
    #1 rst = 1'b1;
    #1;
    chk("abort aluout", {16'b0, aluout}, 32'd0);
    chk("abort flags",  {28'b0, flags},  32'd0);
    chk("abort busy",   {31'b0, busy},   32'd0);
    chk("abort done",   {31'b0, done},   32'd0);
    q.delete();
    @(posedge clk); @(negedge clk); #1;
    rst = 1'b0;
    repeat (25) idle();
    alu("A after rst", OP_ADD, 16'h0000, 16'h0000, 4'b0001);
    alu("add post rst", OP_ADD, 16'h0009, 16'h0009, 4'b0000);
    idle(); idle();

    for (int i = 0; i < 50 && q.size() > 0; i++) idle();
    chk("scoreboard drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
